// File: rtl/cmp_seq.sv
// cmp_seq: sequential magnitude/equality comparator.
// Compares two WIDTH-bit operands CHUNK bits per cycle, starting with the most-significant chunk.
// The start/busy/done handshake accepts a new request only in IDLE.
// Optional build macro: CMP_EARLY_EXIT_EN. When it is defined, RUN leaves as soon as the
// first differing chunk is seen. When it is undefined, RUN always scans all N chunks.
module cmp_seq #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 2,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]    CNT_FULL  = CW'(N);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_decided;
  logic             r_gt;
  logic             r_lt;
  logic             r_busy;
  logic             r_done;
  logic             r_aeqb;
  logic             r_agtb;
  logic             r_altb;

  logic [CHUNK-1:0] w_mask;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_diff;
  logic             w_dec_nxt;
  logic             w_gt_nxt;
  logic             w_lt_nxt;
  logic             w_exit;

  assign busy = r_busy;
  assign done = r_done;
  assign aeqb = r_aeqb;
  assign agtb = r_agtb;
  assign altb = r_altb;

  // Compare the current top chunk. A decided result is sticky, and the exit condition is derived here.
  always_comb begin
    w_mask    = {CHUNK{1'b0}};
    w_ca      = {CHUNK{1'b0}};
    w_cb      = {CHUNK{1'b0}};
    w_diff    = 1'b0;
    w_dec_nxt = 1'b0;
    w_gt_nxt  = 1'b0;
    w_lt_nxt  = 1'b0;
    w_exit    = 1'b0;
    // The sign bit lives only in the first chunk. Flipping it in both operands
    // turns a two's-complement comparison into an unsigned one.
    if ((SIGNED != 0) && (r_cnt == CNT_FULL)) begin
      w_mask = SIGN_MASK;
    end else begin
      w_mask = {CHUNK{1'b0}};
    end
    w_ca      = r_a[WIDTH-1 -: CHUNK] ^ w_mask;
    w_cb      = r_b[WIDTH-1 -: CHUNK] ^ w_mask;
    w_diff    = (w_ca != w_cb);
    w_dec_nxt = r_decided | w_diff;
    if (r_decided) begin
      w_gt_nxt = r_gt;
      w_lt_nxt = r_lt;
    end else begin
      w_gt_nxt = (w_ca > w_cb);
      w_lt_nxt = (w_ca < w_cb);
    end
`ifdef CMP_EARLY_EXIT_EN
    w_exit = (r_cnt == CNT_ONE) | (w_diff & ~r_decided);
`else
    w_exit = (r_cnt == CNT_ONE);
`endif
  end

  // Control FSM, operand shift registers, chunk counter and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aeqb    <= 1'b0;
      r_agtb    <= 1'b0;
      r_altb    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_cnt     <= CNT_FULL;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_a       <= r_a << CHUNK;
          r_b       <= r_b << CHUNK;
          r_cnt     <= r_cnt - CNT_ONE;
          r_decided <= w_dec_nxt;
          r_gt      <= w_gt_nxt;
          r_lt      <= w_lt_nxt;
          if (w_exit) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_aeqb  <= ~w_dec_nxt;
            r_agtb  <= w_dec_nxt & w_gt_nxt;
            r_altb  <= w_dec_nxt & w_lt_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq.sv
// Testbench for cmp_seq. It instantiates three DUTs:
//   u0: unsigned 16/2
//   u1: signed 16/2 (shares stimulus with u0)
//   u2: unsigned 8/8
// A reference model, computed from plain integer comparisons, gives the expected result.
// The expected latency is taken from the position of the first differing bit.
module tb_cmp_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  wire  [4:0]  o0;  // {busy, done, aeqb, agtb, altb}
  wire  [4:0]  o1;
  wire  [4:0]  o2;

  int n_total;
  int n_fail;

  cmp_seq #(.WIDTH(16), .CHUNK(2), .SIGNED(0)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a16), .b(b16),
    .busy(o0[4]), .done(o0[3]), .aeqb(o0[2]), .agtb(o0[1]), .altb(o0[0])
  );

  cmp_seq #(.WIDTH(16), .CHUNK(2), .SIGNED(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a16), .b(b16),
    .busy(o1[4]), .done(o1[3]), .aeqb(o1[2]), .agtb(o1[1]), .altb(o1[0])
  );

  cmp_seq #(.WIDTH(8), .CHUNK(8), .SIGNED(0)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(o2[4]), .done(o2[3]), .aeqb(o2[2]), .agtb(o2[1]), .altb(o2[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The done cycle (relative to the accepting edge T0) is the first differing chunk index plus one.
  // With early exit disabled, it is always N+1.
  function automatic int exp_lat(input logic [31:0] x, input int w, input int c);
    int top;
    top = -1;
    for (int p = w - 1; p >= 0; p--) begin
      if (x[p] && (top < 0)) top = p;
    end
    if (top < 0) return w / c + 1;
`ifdef CMP_EARLY_EXIT_EN
    return (w - 1 - top) / c + 2;
`else
    return w / c + 1;
`endif
  endfunction

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input bit poke);
    int lat;
    int dc0;
    int dc1;
    int bc0;
    int bc1;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] e0;
    logic [2:0] e1;
    lat = exp_lat({16'h0000, av ^ bv}, 16, 2);
    e0  = {av == bv, av > bv, av < bv};
    e1  = {av == bv, $signed(av) > $signed(bv), $signed(av) < $signed(bv)};
    r0  = 3'b000;
    r1  = 3'b000;
    dc0 = 0; dc1 = 0; bc0 = 0; bc1 = 0;
    @(negedge clk);
    a16 = av; b16 = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; (k <= 40) && ((dc0 == 0) || (dc1 == 0)); k++) begin
      if (poke && (k == 3)) begin
        a16 = 16'h0000; b16 = 16'hFFFF; start = 1'b1;
      end
      if (poke && (k == 4)) start = 1'b0;
      if (o0[4]) bc0++;
      if (o1[4]) bc1++;
      if (o0[3] && (dc0 == 0)) begin dc0 = k; r0 = o0[2:0]; end
      if (o1[3] && (dc1 == 0)) begin dc1 = k; r1 = o1[2:0]; end
      if ((dc0 == 0) || (dc1 == 0)) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    chk("u0 done cycle", dc0, lat);
    chk("u1 done cycle", dc1, lat);
    chk("u0 busy cycles", bc0, lat - 1);
    chk("u1 busy cycles", bc1, lat - 1);
    chk("u0 result", 32'(r0), 32'(e0));
    chk("u1 result", 32'(r1), 32'(e1));
    @(posedge clk);
    #1;
    chk("u0 after done", 32'(o0), 32'({2'b00, e0}));
    chk("u1 after done", 32'(o1), 32'({2'b00, e1}));
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv);
    int dc;
    int bc;
    logic [2:0] r;
    logic [2:0] e;
    e  = {av == bv, av > bv, av < bv};
    r  = 3'b000;
    dc = 0; bc = 0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int k = 1; (k <= 20) && (dc == 0); k++) begin
      if (o2[4]) bc++;
      if (o2[3]) begin dc = k; r = o2[2:0]; end
      if (dc == 0) begin
        @(posedge clk);
        #1;
      end
    end
    chk("u2 done cycle", dc, 2);
    chk("u2 busy cycles", bc, 1);
    chk("u2 result", 32'(r), 32'(e));
    @(posedge clk);
    #1;
    chk("u2 after done", 32'(o2), 32'({2'b00, e}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [4:0]  acc;
    n_total = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    start8  = 1'b0;
    a16 = 16'h0000; b16 = 16'h0000; a8 = 8'h00; b8 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("u0 reset", 32'(o0), 32'd0);
    chk("u1 reset", 32'(o1), 32'd0);
    chk("u2 reset", 32'(o2), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("u0 idle after reset", 32'(o0), 32'd0);

    // Directed cases.
    op16(16'h1234, 16'h1234, 1'b0);
    op16(16'h8000, 16'h0000, 1'b0);
    op16(16'h8000, 16'h0001, 1'b0);
    op16(16'hFFFF, 16'hFFFE, 1'b0);
    op16(16'h7FFF, 16'h8000, 1'b0);
    op16(16'h00FF, 16'h00F0, 1'b1);
    op16(16'h0003, 16'h0001, 1'b0);

    // Reset while an operation is running.
    @(negedge clk);
    a16 = 16'h00FF; b16 = 16'h00F0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    chk("u0 mid reset", 32'(o0), 32'd0);
    chk("u1 mid reset", 32'(o1), 32'd0);
    chk("u2 mid reset", 32'(o2), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    acc = 5'b00000;
    repeat (12) begin
      @(posedge clk);
      #1;
      acc = acc | o0 | o1;
    end
    chk("quiet after reset", 32'(acc), 32'd0);
    op16(16'h0001, 16'h0002, 1'b0);

    // Single-chunk configuration, back to back.
    op8(8'h10, 8'h20);
    op8(8'h55, 8'h55);
    op8(8'hF0, 8'h0F);

    // Randomised operands: random, equal, or a single flipped bit.
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(2, 0))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'h0001 << $urandom_range(15, 0));
      endcase
      op16(ra, rb, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      if (i % 3 == 0) rb = ra;
      else rb = 16'($urandom);
      op8(ra[7:0], rb[7:0]);
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
